// File: rtl/multiplier_rr_sequencer_pkg.sv
// Shared definitions for the round-robin shift-add multiplier sequencer.
// Contents: the default operand width, the FSM state encoding and the
// round-robin winner selection helper.
package multiplier_rr_sequencer_pkg;

    localparam int unsigned DefaultN = 8;

    localparam logic IdleEnc = 1'b0;
    localparam logic CalcEnc = 1'b1;

    typedef enum logic {
        StIdle = IdleEnc,
        StCalc = CalcEnc
    } state_e;

    // Returns the winning requester index (0 or 1). With both requests high,
    // the requester that did not own the previous operation wins.
    function automatic logic pick_winner(input logic req0, input logic req1,
                                         input logic last_owner);
        if (req0 && req1) begin
            return ~last_owner;
        end
        return req1;
    endfunction

endpackage

// File: rtl/multiplier_rr_sequencer_if.sv
// Requester-side bus of the shared multiplier.
//   master: operand source(s) - drive req0/a0/b0, req1/a1/b1; observe grants,
//           done pulses, busy and the result.
//   slave : the sequencer - the reverse directions.
interface multiplier_rr_sequencer_if
    import multiplier_rr_sequencer_pkg::*;
#(
    parameter int unsigned N = DefaultN
);

    logic           req0;
    logic [N-1:0]   a0;
    logic [N-1:0]   b0;
    logic           req1;
    logic [N-1:0]   a1;
    logic [N-1:0]   b1;
    logic           gnt0;
    logic           gnt1;
    logic           done0;
    logic           done1;
    logic           busy;
    logic [2*N-1:0] result;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt0, gnt1, done0, done1, busy, result
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt0, gnt1, done0, done1, busy, result
    );

endinterface

// File: rtl/multiplier_rr_sequencer_shift_add_datapath.sv
// Iterative shift-add datapath for an N x N unsigned multiply.
//   clk_i, rst_i : clock and asynchronous active-high reset
//   load_i       : capture a_i (zero-extended) / b_i, clear accumulator and count
//   step_i       : perform one add/shift iteration
//   a_i, b_i     : multiplicand / multiplier operands
//   sum_o        : accumulator including the current iteration's add
//   last_o       : high while the current iteration is the final (N-th) one
module shift_add_datapath #(
    parameter int unsigned N = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] sum_o,
    output logic           last_o
);

    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    logic [2*N-1:0] mcand_q;
    logic [N-1:0]   mplier_q;
    logic [2*N-1:0] acc_q;
    logic [CntW-1:0] cnt_q;

    // The product of N-bit operands always fits in 2N bits, so no carry out.
    always_comb begin
        sum_o = acc_q;
        if (mplier_q[0]) begin
            sum_o = acc_q + mcand_q;
        end
    end

    assign last_o = (cnt_q == CntW'(N - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            mcand_q  <= {{N{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step_i) begin
            acc_q    <= sum_o;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/multiplier_rr_sequencer.sv
// Shares one iterative shift-add multiplier between two requesters.
// Round-robin arbitration picks a winner in IDLE, its operands are captured
// with a one-cycle grant pulse, N add/shift cycles run in CALC, and the 2N-bit
// product is returned with a one-cycle done pulse to the owner.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of multiplier_rr_sequencer_if (req/operands in;
//         gnt0/gnt1, done0/done1, busy, result out)
module multiplier_rr_sequencer
    import multiplier_rr_sequencer_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic                        clk,
    input  logic                        rst,
    multiplier_rr_sequencer_if.slave    bus
);

    state_e         state_q, state_d;
    logic           owner_q, owner_d;
    logic           last_owner_q, last_owner_d;
    logic [2*N-1:0] result_q, result_d;
    logic           gnt0_q, gnt0_d;
    logic           gnt1_q, gnt1_d;
    logic           done0_q, done0_d;
    logic           done1_q, done1_d;

    logic           winner;
    logic           dp_load;
    logic           dp_step;
    logic [N-1:0]   dp_a;
    logic [N-1:0]   dp_b;
    logic [2*N-1:0] dp_sum;
    logic           dp_last;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        result_d     = result_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        dp_load      = 1'b0;
        dp_step      = 1'b0;
        winner       = pick_winner(bus.req0, bus.req1, last_owner_q);

        unique case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    dp_load = 1'b1;
                    owner_d = winner;
                    gnt0_d  = ~winner;
                    gnt1_d  = winner;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                dp_step = 1'b1;
                if (dp_last) begin
                    result_d     = dp_sum;
                    done0_d      = ~owner_q;
                    done1_d      = owner_q;
                    last_owner_d = owner_q;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign dp_a = winner ? bus.a1 : bus.a0;
    assign dp_b = winner ? bus.b1 : bus.b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;  // requester 0 wins the first tie
            result_q     <= '0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            result_q     <= result_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
        end
    end

    shift_add_datapath #(
        .N (N)
    ) u_datapath (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (dp_load),
        .step_i (dp_step),
        .a_i    (dp_a),
        .b_i    (dp_b),
        .sum_o  (dp_sum),
        .last_o (dp_last)
    );

    assign bus.gnt0   = gnt0_q;
    assign bus.gnt1   = gnt1_q;
    assign bus.done0  = done0_q;
    assign bus.done1  = done1_q;
    assign bus.busy   = (state_q == StCalc);
    assign bus.result = result_q;

endmodule

// File: tb/tb_multiplier_rr_sequencer.sv
// Self-checking bench for multiplier_rr_sequencer (N = 8).
module tb_multiplier_rr_sequencer;

    localparam int unsigned N = 8;
    localparam int unsigned W = 2 * N;

    logic clk;
    logic rst;

    multiplier_rr_sequencer_if #(.N(N)) bus ();

    multiplier_rr_sequencer #(
        .N (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Reference state: who owned the last completed operation and its product.
    logic         m_last;
    logic [W-1:0] m_result;

    typedef struct {
        logic         r0;
        logic         r1;
        logic [N-1:0] a0;
        logic [N-1:0] b0;
        logic [N-1:0] a1;
        logic [N-1:0] b1;
        logic         owner;
        logic [W-1:0] product;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [W-1:0] mul(input logic [N-1:0] x, input logic [N-1:0] y);
        int unsigned p;
        p = int'(x) * int'(y);
        return W'(p);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " busy"},   64'(bus.busy),   64'(0));
        check({tag, " gnt0"},   64'(bus.gnt0),   64'(0));
        check({tag, " gnt1"},   64'(bus.gnt1),   64'(0));
        check({tag, " done0"},  64'(bus.done0),  64'(0));
        check({tag, " done1"},  64'(bus.done1),  64'(0));
        check({tag, " result"}, 64'(bus.result), 64'(m_result));
    endtask

    // Called at a negedge. Presents requests, then checks the fixed timeline:
    // grant in cycle 1, busy in cycles 1..N, done and result in cycle N+1.
    // The winner drops its request after its grant and scrambles its operands.
    task automatic op(input logic r0, input logic r1,
                      input logic [N-1:0] x0, input logic [N-1:0] y0,
                      input logic [N-1:0] x1, input logic [N-1:0] y1,
                      input logic w, input logic [W-1:0] p, input string tag);
        bus.req0 = r0;
        bus.a0   = x0;
        bus.b0   = y0;
        bus.req1 = r1;
        bus.a1   = x1;
        bus.b1   = y1;
        for (int c = 1; c <= N + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check($sformatf("%s gnt0 c%0d", tag, c), 64'(bus.gnt0), 64'(w == 1'b0));
                check($sformatf("%s gnt1 c%0d", tag, c), 64'(bus.gnt1), 64'(w == 1'b1));
            end else begin
                check($sformatf("%s gnt0 c%0d", tag, c), 64'(bus.gnt0), 64'(0));
                check($sformatf("%s gnt1 c%0d", tag, c), 64'(bus.gnt1), 64'(0));
            end
            if (c <= N) begin
                check($sformatf("%s busy c%0d", tag, c), 64'(bus.busy), 64'(1));
                check($sformatf("%s done0 c%0d", tag, c), 64'(bus.done0), 64'(0));
                check($sformatf("%s done1 c%0d", tag, c), 64'(bus.done1), 64'(0));
                check($sformatf("%s hold c%0d", tag, c), 64'(bus.result), 64'(m_result));
            end else begin
                check($sformatf("%s busy end", tag), 64'(bus.busy), 64'(0));
                check($sformatf("%s done0 end", tag), 64'(bus.done0), 64'(w == 1'b0));
                check($sformatf("%s done1 end", tag), 64'(bus.done1), 64'(w == 1'b1));
                check($sformatf("%s result", tag), 64'(bus.result), 64'(p));
            end
            if (c == 1) begin
                if (w) begin
                    bus.req1 = 1'b0;
                    bus.a1   = N'($urandom);
                    bus.b1   = N'($urandom);
                end else begin
                    bus.req0 = 1'b0;
                    bus.a0   = N'($urandom);
                    bus.b0   = N'($urandom);
                end
            end
        end
        m_last   = w;
        m_result = p;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        m_last   = 1'b1;
        m_result = '0;
    endtask

    initial begin
        logic [N-1:0] fa0, fb0, fa1, fb1;
        logic         h0, h1, w;
        logic [N-1:0] ra0, rb0, ra1, rb1;

        checks   = 0;
        errors   = 0;
        m_last   = 1'b1;
        m_result = '0;
        rst      = 1'b1;
        bus.req0 = 1'b0;
        bus.a0   = '0;
        bus.b0   = '0;
        bus.req1 = 1'b0;
        bus.a1   = '0;
        bus.b1   = '0;

        vecs[0] = '{1'b1, 1'b1, 8'd7,   8'd9,   8'd12, 8'd12,  1'b0, 16'h003F};
        vecs[1] = '{1'b0, 1'b1, 8'd7,   8'd9,   8'd12, 8'd12,  1'b1, 16'h0090};
        vecs[2] = '{1'b1, 1'b0, 8'd5,   8'd3,   8'd0,  8'd0,   1'b0, 16'h000F};
        vecs[3] = '{1'b1, 1'b0, 8'd255, 8'd255, 8'd0,  8'd0,   1'b0, 16'hFE01};
        vecs[4] = '{1'b1, 1'b0, 8'd0,   8'd200, 8'd0,  8'd0,   1'b0, 16'h0000};
        vecs[5] = '{1'b0, 1'b1, 8'd0,   8'd0,   8'd1,  8'd255, 1'b1, 16'h00FF};

        // Reset state, both while held and after release.
        repeat (2) @(negedge clk);
        check_quiet("reset held");
        rst = 1'b0;
        @(negedge clk);
        check_quiet("reset released");

        // Table: tie after reset, single requests, operand extremes.
        for (int i = 0; i < 6; i++) begin
            op(vecs[i].r0, vecs[i].r1, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
               vecs[i].owner, vecs[i].product, $sformatf("vec%0d", i));
        end

        // Fairness: both requests held, grants must go 0,1,0,1.
        fa0 = N'($urandom);
        fb0 = N'($urandom);
        fa1 = N'($urandom);
        fb1 = N'($urandom);
        for (int k = 0; k < 4; k++) begin
            w = k[0];
            op(1'b1, 1'b1, fa0, fb0, fa1, fb1, w, w ? mul(fa1, fb1) : mul(fa0, fb0),
               $sformatf("fair%0d", k));
            if (w) begin
                fa1 = N'($urandom);
                fb1 = N'($urandom);
            end else begin
                fa0 = N'($urandom);
                fb0 = N'($urandom);
            end
        end
        // Requester 0 still holds its request; it is served next.
        op(1'b1, 1'b0, fa0, fb0, fa1, fb1, 1'b0, mul(fa0, fb0), "fair_tail");

        // Idle with no requests: nothing moves, result held.
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_quiet("idle");
        end

        // Abort: asynchronous reset mid-cycle during CALC cycle 4.
        bus.req0 = 1'b1;
        bus.a0   = 8'd9;
        bus.b0   = 8'd9;
        @(negedge clk);
        check("abort gnt0", 64'(bus.gnt0), 64'(1));
        bus.req0 = 1'b0;
        repeat (3) @(negedge clk);
        check("abort busy c4", 64'(bus.busy), 64'(1));
        #2 rst = 1'b1;
        #1;
        m_result = '0;
        check_quiet("abort async");
        @(negedge clk);
        rst    = 1'b0;
        m_last = 1'b1;
        repeat (N + 2) begin
            @(negedge clk);
            check_quiet("abort no done");
        end
        op(1'b0, 1'b1, 8'd0, 8'd0, 8'd3, 8'd4, 1'b1, 16'h000C, "abort_req1");

        // Fresh reset then a tie: requester 0 first, then the held requester 1.
        do_reset();
        check_quiet("reset2");
        op(1'b1, 1'b1, 8'd2, 8'd3, 8'd4, 8'd5, 1'b0, 16'h0006, "tie2_a");
        op(1'b0, 1'b1, 8'd2, 8'd3, 8'd4, 8'd5, 1'b1, 16'h0014, "tie2_b");

        // Randomized traffic against the transaction-level model.
        h0 = 1'b0;
        h1 = 1'b0;
        ra0 = '0;
        rb0 = '0;
        ra1 = '0;
        rb1 = '0;
        for (int i = 0; i < 16; i++) begin
            if (!h0 && ($urandom_range(0, 1) == 1)) begin
                h0  = 1'b1;
                ra0 = N'($urandom);
                rb0 = N'($urandom);
            end
            if (!h1 && ($urandom_range(0, 1) == 1)) begin
                h1  = 1'b1;
                ra1 = N'($urandom);
                rb1 = N'($urandom);
            end
            if (!h0 && !h1) begin
                h1  = 1'b1;
                ra1 = N'($urandom);
                rb1 = N'($urandom);
            end
            w = (h0 && h1) ? ~m_last : h1;
            op(h0, h1, ra0, rb0, ra1, rb1, w, w ? mul(ra1, rb1) : mul(ra0, rb0),
               $sformatf("rand%0d", i));
            if (w) h1 = 1'b0;
            else   h0 = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
